// File: rtl/seq_divider.sv
// Sequential signed divider: 32 restoring steps on magnitudes, then a
// two-cycle fix-up that applies the signs and publishes the results.
module seq_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [31:0] quo_work;
  logic [31:0] rem_work;
  logic [31:0] dsr_abs;
  logic [4:0]  count;
  logic        quo_neg;
  logic        rem_neg;
  logic        fix_applied;

  // Magnitudes are unsigned, so 0x80000000 becomes 2^31 without overflow.
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  assign dividend_abs = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign divisor_abs  = divisor[31]  ? (~divisor + 32'd1)  : divisor;

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  logic [32:0] shifted;
  logic [32:0] trial;
  assign shifted = {rem_work, quo_work[31]};
  assign trial   = shifted - {1'b0, dsr_abs};

  // Control FSM and datapath; published outputs change only on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      quo_work    <= '0;
      rem_work    <= '0;
      dsr_abs     <= '0;
      count       <= '0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      fix_applied <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == 32'd0) begin
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
            end else begin
              quo_work    <= dividend_abs;
              rem_work    <= '0;
              dsr_abs     <= divisor_abs;
              quo_neg     <= dividend[31] ^ divisor[31];
              rem_neg     <= dividend[31];
              count       <= '0;
              fix_applied <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          quo_work <= {quo_work[30:0], ~trial[32]};
          rem_work <= trial[32] ? shifted[31:0] : trial[31:0];
          count    <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!fix_applied) begin
            quo_work    <= quo_neg ? (~quo_work + 32'd1) : quo_work;
            rem_work    <= rem_neg ? (~rem_work + 32'd1) : rem_work;
            fix_applied <= 1'b1;
          end else begin
            quotient    <= quo_work;
            remainder   <= rem_work;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every ready pulse.
module tb_seq_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        busy;
  logic        div_by_zero;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .ready(ready),
    .busy(busy),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used to measure completion latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Drives one start pulse; returns just after the sampling edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input bit expect_resp);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (expect_resp) begin
      e.q         = eq;
      e.r         = er;
      e.dbz       = edbz;
      e.start_cyc = cyc;
      e.lat       = (b == 32'd0) ? 0 : 34;
      sb.push_back(e);
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checkOutput("completion_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request
  always @(negedge clock) begin
    exp_t e;
    if (!reset && ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ready actual=1 expected=0 q=0x%08h r=0x%08h", quotient, remainder);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput("latency", cyc - e.start_cyc, e.lat);
      end
    end
  end

  initial begin
    int busy_cycles;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_ready", {31'd0, ready}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] 100/7 with busy length and hold checks");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
      if (i == 10) begin
        checkOutput("hold_quotient", quotient, 0);
        checkOutput("hold_remainder", remainder, 0);
      end
    end
    checkOutput("busy_cycles", busy_cycles, 34);
    waitDone();

    $display("[TB] signed cases");
    applyStimulus(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1);
    checkOutput("busy_after_start", {31'd0, busy}, 1);
    waitDone();
    applyStimulus(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b1);
    waitDone();
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
    waitDone();
    applyStimulus(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 1'b1);
    waitDone();

    $display("[TB] divide by zero");
    applyStimulus(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b1);
    checkOutput("busy_dbz", {31'd0, busy}, 0);
    waitDone();
    applyStimulus(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
    waitDone();

    $display("[TB] start while busy is ignored");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (4) @(posedge clock);
    applyStimulus(32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    waitDone();
    repeat (40) @(posedge clock);
    #1;

    $display("[TB] reset aborts operation");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (4) @(posedge clock);
    applyStimulus(32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_ready", {31'd0, ready}, 0);
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_dbz", {31'd0, div_by_zero}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("post_abort_busy", {31'd0, busy}, 0);
    applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
    waitDone();

    $display("[TB] back-to-back on ready cycle");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 60 && !ready; i++) @(negedge clock);
    if (!ready) checkOutput("b2b_ready_timeout", {31'd0, ready}, 1);
    applyStimulus(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    checkOutput("b2b_busy", {31'd0, busy}, 1);
    waitDone();

    repeat (5) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
